// File: rtl/qei_pkg.sv
// Shared definitions for the QEI blocks: step encoding, direction codes and
// a saturating step accumulator helper.
package qei_pkg;

   // 2-bit step encoding: bit0 = forward pulse, bit1 = backward pulse.
   localparam logic [1:0] STEP_NONE    = 2'b00;
   localparam logic [1:0] STEP_FWD     = 2'b01;
   localparam logic [1:0] STEP_BWD     = 2'b10;
   localparam logic [1:0] STEP_ILLEGAL = 2'b11;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_BWD = 1'b1;

   // Add +1/-1/0 for the step code to acc, clamped to the signed range of a
   // w-bit value. Illegal and idle codes leave acc untouched.
   function automatic logic signed [31:0] sat_add(input logic signed [31:0] acc,
                                                  input logic [1:0]         step,
                                                  input int                 w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      logic signed [31:0] r;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      r  = acc;
      if (step == STEP_FWD && acc < hi) begin
         r = acc + 32'sd1;
      end else if (step == STEP_BWD && acc > lo) begin
         r = acc - 32'sd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/qei_period_timer.sv
// Step-to-step period timer: counts cycles between same-direction steps,
// invalidates on reversal, and flags a stall when the counter saturates.
module qei_period_timer
   import qei_pkg::*;
#(
   parameter int PER_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic [1:0]       step_i,
   output logic [PER_W-1:0] period_o,
   output logic             period_valid_o,
   output logic             stalled_o
);

   localparam logic [PER_W-1:0] CNT_MAX = '1;
   localparam logic [PER_W-1:0] CNT_ONE = PER_W'(1);

   logic [PER_W-1:0] cnt_q, cnt_d;
   logic [PER_W-1:0] period_q, period_d;
   logic             dir_q, dir_d;
   logic             armed_q, armed_d;   // a timing reference step exists
   logic             valid_q, valid_d;
   logic             stalled_q, stalled_d;
   logic             step_vld;
   logic             step_dir;

   assign step_vld = (step_i == STEP_FWD) || (step_i == STEP_BWD);
   assign step_dir = (step_i == STEP_BWD) ? DIR_BWD : DIR_FWD;

   // Next-state: disable clears timing, steps close/restart a period, idle counts up.
   always_comb begin
      cnt_d     = cnt_q;
      period_d  = period_q;
      dir_d     = dir_q;
      armed_d   = armed_q;
      valid_d   = valid_q;
      stalled_d = stalled_q;
      if (!en_i) begin
         cnt_d   = CNT_ONE;
         armed_d = 1'b0;
         valid_d = 1'b0;
      end else if (step_vld) begin
         if (armed_q && step_dir == dir_q) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
         end else begin
            valid_d  = 1'b0;
         end
         cnt_d     = CNT_ONE;
         dir_d     = step_dir;
         armed_d   = 1'b1;
         stalled_d = 1'b0;
      end else if (cnt_q == CNT_MAX) begin
         // counter holds at max until the next step
         stalled_d = 1'b1;
         valid_d   = 1'b0;
         period_d  = CNT_MAX;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= CNT_ONE;
         period_q  <= '0;
         dir_q     <= DIR_FWD;
         armed_q   <= 1'b0;
         valid_q   <= 1'b0;
         stalled_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         dir_q     <= dir_d;
         armed_q   <= armed_d;
         valid_q   <= valid_d;
         stalled_q <= stalled_d;
      end
   end

   assign period_o       = period_q;
   assign period_valid_o = valid_q;
   assign stalled_o      = stalled_q;

endmodule

// File: rtl/qei_velocity.sv
// QEI velocity measurement: signed net steps per gate window (high speed)
// and step-to-step period (low speed), all outputs registered.
module qei_velocity
   import qei_pkg::*;
#(
   parameter int WINDOW_CYCLES = 1000,
   parameter int VEL_W         = 12,
   parameter int PER_W         = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    step_fwd,
   input  logic                    step_bwd,
   output logic signed [VEL_W-1:0] vel_out,
   output logic                    vel_strobe,
   output logic [PER_W-1:0]        period_out,
   output logic                    period_valid,
   output logic                    stalled
);

   localparam int               WIN_W    = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

   logic [WIN_W-1:0]        win_q, win_d;
   logic signed [VEL_W-1:0] acc_q, acc_d;
   logic signed [VEL_W-1:0] vel_q, vel_d;
   logic                    strobe_q, strobe_d;
   logic signed [VEL_W-1:0] acc_sum;
   logic [1:0]              step_code;

   assign step_code = {step_bwd, step_fwd};
   // Saturating sum including this cycle's step (illegal code adds nothing).
   assign acc_sum   = VEL_W'(sat_add(32'(acc_q), step_code, VEL_W));

   // Next-state: accumulate across the window, publish and clear on its last cycle.
   always_comb begin
      win_d    = win_q;
      acc_d    = acc_q;
      vel_d    = vel_q;
      strobe_d = 1'b0;
      if (!en) begin
         win_d = '0;
         acc_d = '0;
      end else if (win_q == WIN_LAST) begin
         vel_d    = acc_sum;
         acc_d    = '0;
         win_d    = '0;
         strobe_d = 1'b1;
      end else begin
         acc_d = acc_sum;
         win_d = win_q + WIN_W'(1);
      end
   end

   // Window state and registered velocity outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q    <= '0;
         acc_q    <= '0;
         vel_q    <= '0;
         strobe_q <= 1'b0;
      end else begin
         win_q    <= win_d;
         acc_q    <= acc_d;
         vel_q    <= vel_d;
         strobe_q <= strobe_d;
      end
   end

   assign vel_out    = vel_q;
   assign vel_strobe = strobe_q;

   qei_period_timer #(
      .PER_W (PER_W)
   ) u_period (
      .clk            (clk),
      .rst_n          (rst_n),
      .en_i           (en),
      .step_i         (step_code),
      .period_o       (period_out),
      .period_valid_o (period_valid),
      .stalled_o      (stalled)
   );

endmodule

// File: tb/tb_qei_velocity.sv
// Bench for qei_velocity: table-driven windows, hand sequences for period,
// stall, reset and enable, then random traffic against a cycle-level model.
module tb_qei_velocity;

   localparam int W0   = 16;
   localparam int W1   = 200;
   localparam int VW   = 6;
   localparam int PW   = 8;
   localparam int VMAX = 31;
   localparam int VMIN = -32;
   localparam int PMAX = 255;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic step_fwd = 1'b0;
   logic step_bwd = 1'b0;

   logic signed [VW-1:0] vel0, vel1;
   logic                 str0, str1;
   logic [PW-1:0]        per0, per1;
   logic                 pv0, pv1, st0, st1;

   qei_velocity #(.WINDOW_CYCLES(W0), .VEL_W(VW), .PER_W(PW)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .step_fwd(step_fwd), .step_bwd(step_bwd),
      .vel_out(vel0), .vel_strobe(str0), .period_out(per0), .period_valid(pv0), .stalled(st0));

   qei_velocity #(.WINDOW_CYCLES(W1), .VEL_W(VW), .PER_W(PW)) u_sat (
      .clk(clk), .rst_n(rst_n), .en(en), .step_fwd(step_fwd), .step_bwd(step_bwd),
      .vel_out(vel1), .vel_strobe(str1), .period_out(per1), .period_valid(pv1), .stalled(st1));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   int m_wlen[2] = '{W0, W1};
   int m_win[2];
   int m_acc[2];
   int m_vel[2];
   bit m_str[2];
   int cyc;
   int m_last;     // cycle index of last step / enable-low / reset
   int m_per;
   bit m_have, m_dir, m_valid, m_stall;

   typedef struct {
      string       name;
      logic [15:0] fwd;
      logic [15:0] bwd;
      int          vel;
   } win_vec_t;

   win_vec_t tbl[7];

   task automatic chk(input string name, input logic signed [31:0] act,
                      input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_win[i] = 0; m_acc[i] = 0; m_vel[i] = 0; m_str[i] = 0;
      end
      cyc = 0; m_last = -1; m_per = 0;
      m_have = 0; m_dir = 0; m_valid = 0; m_stall = 0;
   endtask

   task automatic model_step(input bit e, input bit f, input bit b);
      int d, a;
      bit s;
      s = f ^ b;
      d = s ? (f ? 1 : -1) : 0;
      for (int i = 0; i < 2; i++) begin
         if (!e) begin
            m_win[i] = 0; m_acc[i] = 0; m_str[i] = 0;
         end else begin
            a = m_acc[i] + d;
            if (a > VMAX) a = VMAX;
            if (a < VMIN) a = VMIN;
            if (m_win[i] == m_wlen[i] - 1) begin
               m_vel[i] = a; m_acc[i] = 0; m_win[i] = 0; m_str[i] = 1;
            end else begin
               m_acc[i] = a; m_win[i]++; m_str[i] = 0;
            end
         end
      end
      if (!e) begin
         m_last = cyc; m_have = 0; m_valid = 0;
      end else if (s) begin
         if (m_have && m_dir == b) begin
            m_per = (cyc - m_last > PMAX) ? PMAX : cyc - m_last;
            m_valid = 1;
         end else begin
            m_valid = 0;
         end
         m_dir = b; m_have = 1; m_last = cyc; m_stall = 0;
      end else if (cyc - m_last >= PMAX) begin
         m_stall = 1; m_valid = 0; m_per = PMAX;
      end
      cyc++;
   endtask

   task automatic cmp_all();
      chk("vel0", vel0, m_vel[0]);
      chk("strobe0", str0, m_str[0]);
      chk("vel1", vel1, m_vel[1]);
      chk("strobe1", str1, m_str[1]);
      chk("period0", per0, m_per);
      chk("pvalid0", pv0, m_valid);
      chk("stalled0", st0, m_stall);
      chk("period1", per1, m_per);
      chk("pvalid1", pv1, m_valid);
      chk("stalled1", st1, m_stall);
   endtask

   // one clock: drive at negedge, model at posedge, compare at next negedge
   task automatic cyc1(input bit e, input bit f, input bit b);
      en = e; step_fwd = f; step_bwd = b;
      @(posedge clk);
      model_step(e, f, b);
      @(negedge clk);
      cmp_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; step_fwd = 1'b0; step_bwd = 1'b0;
      #1;
      chk("rst_vel0", vel0, 0);
      chk("rst_strobe0", str0, 0);
      chk("rst_period0", per0, 0);
      chk("rst_pvalid0", pv0, 0);
      chk("rst_stalled0", st0, 0);
      chk("rst_vel1", vel1, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int nstr;
      bit f, b;
      int mode, r;

      tbl[0] = '{"fwd5_bwd2",    16'h001F, 16'h0300,  3};
      tbl[1] = '{"idle",         16'h0000, 16'h0000,  0};
      tbl[2] = '{"last_cycle",   16'h8000, 16'h0000,  1};
      tbl[3] = '{"both_illegal", 16'hFFFF, 16'hFFFF,  0};
      tbl[4] = '{"mixed_illeg",  16'hFFFF, 16'h0F0F,  8};
      tbl[5] = '{"cancel",       16'h00FF, 16'hFF00,  0};
      tbl[6] = '{"all_bwd",      16'h0000, 16'hFFFF, -16};

      @(negedge clk);
      en = 1'b1;
      do_reset();

      // table-driven 16-cycle windows, window aligned by an enable-low cycle
      cyc1(0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         for (int c = 0; c < 16; c++) cyc1(1, tbl[i].fwd[c], tbl[i].bwd[c]);
         chk({"tbl_vel_", tbl[i].name}, vel0, tbl[i].vel);
         chk({"tbl_strobe_", tbl[i].name}, str0, 1);
      end

      // saturation on the 200-cycle window instance
      cyc1(0, 0, 0);
      for (int c = 0; c < 200; c++) cyc1(1, 1, 0);
      chk("sat_pos_vel", vel1, 31);
      chk("sat_pos_strobe", str1, 1);
      chk("period_consec", per0, 1);
      for (int c = 0; c < 200; c++) cyc1(1, 0, 1);
      chk("sat_neg_vel", vel1, -32);
      chk("sat_neg_strobe", str1, 1);

      // period, reversal, stall
      cyc1(0, 0, 0);
      for (int c = 0; c < 311; c++) begin
         f = (c == 10 || c == 14 || c == 24 || c == 305 || c == 309);
         b = (c == 30 || c == 33);
         cyc1(1, f, b);
         if (c == 10) chk("per_first_valid", pv0, 0);
         if (c == 14) begin chk("per_4", per0, 4); chk("per_4_valid", pv0, 1); end
         if (c == 24) begin chk("per_10", per0, 10); chk("per_10_valid", pv0, 1); end
         if (c == 30) begin chk("rev_valid", pv0, 0); chk("rev_period", per0, 10); end
         if (c == 33) begin chk("per_3", per0, 3); chk("per_3_valid", pv0, 1); end
         if (c == 287) chk("pre_stall", st0, 0);
         if (c == 288) begin
            chk("stall", st0, 1); chk("stall_period", per0, 255); chk("stall_valid", pv0, 0);
         end
         if (c == 305) begin chk("unstall", st0, 0); chk("unstall_valid", pv0, 0); end
         if (c == 309) begin chk("post_stall_per", per0, 4); chk("post_stall_valid", pv0, 1); end
      end

      // reset mid-window with accumulator at +4
      cyc1(0, 0, 0);
      for (int c = 0; c < 16; c++) cyc1(1, c < 3, 0);
      chk("pre_rst_vel", vel0, 3);
      for (int c = 0; c < 6; c++) cyc1(1, c < 4, 0);
      do_reset();
      nstr = 0;
      for (int c = 0; c < 20; c++) begin
         cyc1(1, 0, 0);
         if (c < 15) nstr += str0;
         if (c == 15) begin chk("rst_win_strobe", str0, 1); chk("rst_win_vel", vel0, 0); end
      end
      chk("rst_no_early_strobe", nstr, 0);

      // enable low mid-window
      cyc1(0, 0, 0);
      for (int c = 0; c < 16; c++) cyc1(1, c < 3, 0);
      chk("en_pre_vel", vel0, 3);
      for (int c = 0; c < 5; c++) cyc1(1, 1, 0);
      nstr = 0;
      for (int c = 0; c < 7; c++) begin
         cyc1(0, 1, 0);
         nstr += str0;
      end
      chk("en_low_vel_held", vel0, 3);
      for (int c = 0; c < 16; c++) begin
         cyc1(1, 0, 0);
         if (c < 15) nstr += str0;
      end
      chk("en_no_early_strobe", nstr, 0);
      chk("en_rise_strobe", str0, 1);
      chk("en_rise_vel", vel0, 0);

      // random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         mode = (k / 500) % 3;
         case (mode)
            0: f = ($urandom_range(0, 1) == 0);
            1: f = ($urandom_range(0, 39) == 0);
            default: f = ($urandom_range(0, 399) == 0);
         endcase
         b = 0;
         if (f) begin
            r = $urandom_range(0, 9);
            if (r == 0) b = 1;
            else if (r < 5) begin f = 0; b = 1; end
         end
         if (k == 1500) do_reset();
         cyc1((mode == 2) ? 1'b1 : ($urandom_range(0, 29) != 0), f, b);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
